// File: rtl/stack_lifo_pkg.sv
// stack_lifo_pkg: operation decode enum and pointer-width helper shared by the stack_lifo block.
package stack_lifo_pkg;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_REPL = 2'b11
   } op_t;

   function automatic int calc_aw(input int depth);
      return $clog2(depth);
   endfunction

   function automatic op_t decode_op(input logic push, input logic pop);
      return op_t'({push, pop});
   endfunction

endpackage

// File: rtl/stack_lifo_mem.sv
// stack_lifo_mem: DEPTH x WIDTH register file, one synchronous write port, one asynchronous read port.
module stack_lifo_mem #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];

endmodule

// File: rtl/stack_lifo.sv
// stack_lifo: LIFO stack with push/pop/replace, flags and over/underflow pulses.
// Define STACK_LIFO_WRAP_EN to make a push while full discard the oldest entry instead of being rejected.
module stack_lifo
   import stack_lifo_pkg::*;
#(
   parameter int WIDTH = 11,
   parameter int DEPTH = 16,
   parameter int AW    = calc_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

`ifdef STACK_LIFO_WRAP_EN
   localparam bit wrap = 1'b1;
`else
   localparam bit wrap = 1'b0;
`endif
   localparam logic [AW-1:0] one_p   = 1;
   localparam logic [AW:0]   one_c   = 1;
   localparam logic [AW:0]   cnt_max = (AW+1)'(DEPTH);

   op_t              op;
   logic [AW-1:0]    ptr;
   logic [AW-1:0]    top_ptr;
   logic [AW-1:0]    waddr;
   logic [AW:0]      cnt;
   logic             is_empty;
   logic             is_full;
   logic             we;
   logic             grow;
   logic             advance;
   logic [WIDTH-1:0] rdata;

   // ptr is the next free slot; when full it also addresses the oldest entry, which wrap mode overwrites
   always_comb begin
      op       = decode_op(push, pop);
      is_empty = cnt == '0;
      is_full  = cnt == cnt_max;
      top_ptr  = ptr - one_p;
      grow     = (op == OP_PUSH && !is_full) || (op == OP_REPL && is_empty);
      advance  = grow || (op == OP_PUSH && wrap);
      we       = rst_n && !clr && (advance || op == OP_REPL);
      waddr    = (op == OP_REPL && !is_empty) ? top_ptr : ptr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         ptr       <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= op == OP_PUSH && is_full;
         underflow <= op == OP_POP && is_empty;
         if (advance) ptr <= ptr + one_p;
         if (grow) cnt <= cnt + one_c;
         if (op == OP_POP && !is_empty) begin
            ptr <= top_ptr;
            cnt <= cnt - one_c;
         end
      end
   end

   stack_lifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (din),
      .raddr (top_ptr),
      .rdata (rdata)
   );

   assign count = cnt;
   assign empty = is_empty;
   assign full  = is_full;
   assign dout  = is_empty ? '0 : rdata;

endmodule
